bcd_calc_core: RTL and testbench



---
 rtl/bcd_calc_core.sv | 234 +++++++++++++++++++++++
 tb/tb_bcd_calc_core.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_calc_core.sv
// Keypad-driven BCD calculator engine: multi-digit operand entry and chained
// sign-magnitude add/subtract, one BCD digit per clock, with a registered display.
module bcd_calc_core #(
  parameter int         DIGITS  = 4,
  parameter logic [3:0] KEY_ADD = 4'hA,
  parameter logic [3:0] KEY_SUB = 4'hB,
  parameter logic [3:0] KEY_CLR = 4'hC,
  parameter logic [3:0] KEY_EQ  = 4'hE,
  parameter logic [3:0] KEY_BS  = 4'hF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          num,
  input  logic                keyPressed,
  output logic [4*DIGITS-1:0] disp_bcd,
  output logic [DIGITS-1:0]   disp_blank,
  output logic                neg,
  output logic                err,
  output logic                busy
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [2:0] {ENTER_A, OP_WAIT, ENTER_B, COMPUTE, SHOW, ERROR} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d, cyc_q, cyc_d;
  logic            sa_q, sa_d, op_q, op_d, next_op_q, next_op_d, chain_q, chain_d;
  logic            eff_sub_q, eff_sub_d, rsign_q, rsign_d, carry_q, carry_d;
  logic            kp_prev_q, kp_prev_d;
  logic [W-1:0]    disp_bcd_q, disp_bcd_d;
  logic [DIGITS-1:0] disp_blank_q, disp_blank_d;
  logic            neg_q, neg_d, err_q, err_d, busy_q, busy_d;

  logic            key_ev, is_dig, is_op, is_eq, is_bs, is_clr, swap, eff_sub;
  logic [4:0]      step;
  logic [W-1:0]    res_nxt;

  function automatic logic [DIGITS-1:0] blank_mask(input logic [W-1:0] v);
    logic hi_zero;
    blank_mask = '0;
    hi_zero    = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      hi_zero       = hi_zero & (v[4*i +: 4] == 4'd0);
      blank_mask[i] = hi_zero;
    end
  endfunction

  function automatic logic [CW-1:0] sig_count(input logic [W-1:0] v);
    sig_count = '0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] != 4'd0) sig_count = CW'(i + 1);
  endfunction

  // Returns {carry/borrow out, result digit}; for subtract x >= y overall is guaranteed.
  function automatic logic [4:0] bcd_step(input logic [3:0] x, input logic [3:0] y,
                                          input logic cin, input logic sub);
    logic [4:0] t;
    if (!sub) begin
      t = {1'b0, x} + {1'b0, y} + {4'd0, cin};
      bcd_step = (t > 5'd9) ? {1'b1, 4'(t + 5'd6)} : {1'b0, t[3:0]};
    end else begin
      t = {1'b0, x} - {1'b0, y} - {4'd0, cin};
      bcd_step = t[4] ? {1'b1, 4'(t + 5'd10)} : {1'b0, t[3:0]};
    end
  endfunction

  function automatic void enter_digit(input logic [W-1:0] v, input logic [CW-1:0] c,
                                      input logic [3:0] d,
                                      output logic [W-1:0] v_o, output logic [CW-1:0] c_o);
    v_o = v;
    c_o = c;
    if (c != CW'(DIGITS) && !(d == 4'd0 && v == '0)) begin
      v_o = {v[W-5:0], d};
      c_o = c + 1'b1;
    end
  endfunction

  function automatic void back_space(input logic [W-1:0] v, input logic [CW-1:0] c,
                                     output logic [W-1:0] v_o, output logic [CW-1:0] c_o);
    v_o = v;
    c_o = c;
    if (c != '0) begin
      v_o = v >> 4;
      c_o = c - 1'b1;
    end
  endfunction

  always_comb begin
    state_d = state_q;  a_d = a_q;  b_d = b_q;  res_d = res_q;
    cnt_a_d = cnt_a_q;  cnt_b_d = cnt_b_q;  cyc_d = cyc_q;
    sa_d = sa_q;  op_d = op_q;  next_op_d = next_op_q;  chain_d = chain_q;
    eff_sub_d = eff_sub_q;  rsign_d = rsign_q;  carry_d = carry_q;
    disp_bcd_d = disp_bcd_q;  disp_blank_d = disp_blank_q;  neg_d = neg_q;
    kp_prev_d = keyPressed;
    swap = 1'b0;  eff_sub = 1'b0;  step = '0;  res_nxt = '0;

    key_ev = keyPressed & ~kp_prev_q;
    is_dig = key_ev && (num <= 4'd9);
    is_op  = key_ev && (num == KEY_ADD || num == KEY_SUB);
    is_eq  = key_ev && (num == KEY_EQ);
    is_bs  = key_ev && (num == KEY_BS);
    is_clr = key_ev && (num == KEY_CLR);

    if (is_clr) begin
      state_d = ENTER_A;  a_d = '0;  b_d = '0;  sa_d = 1'b0;  op_d = 1'b0;
      cnt_a_d = '0;  cnt_b_d = '0;  cyc_d = '0;  chain_d = 1'b0;  carry_d = 1'b0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (is_dig)     enter_digit(a_q, cnt_a_q, num, a_d, cnt_a_d);
          else if (is_bs) back_space(a_q, cnt_a_q, a_d, cnt_a_d);
          else if (is_op) begin
            op_d    = (num == KEY_SUB);
            state_d = OP_WAIT;
          end
        end
        OP_WAIT: begin
          if (is_dig) begin
            enter_digit('0, '0, num, b_d, cnt_b_d);
            state_d = ENTER_B;
          end else if (is_op) begin
            op_d = (num == KEY_SUB);
          end else if (is_eq) begin
            b_d = '0;  cnt_b_d = '0;  chain_d = 1'b0;  cyc_d = '0;
            state_d = COMPUTE;
          end
        end
        ENTER_B: begin
          if (is_dig)     enter_digit(b_q, cnt_b_q, num, b_d, cnt_b_d);
          else if (is_bs) back_space(b_q, cnt_b_q, b_d, cnt_b_d);
          else if (is_eq || is_op) begin
            chain_d   = is_op;
            next_op_d = (num == KEY_SUB);
            cyc_d     = '0;
            state_d   = COMPUTE;
          end
        end
        COMPUTE: begin
          if (cyc_q == '0) begin
            // Order operands so the digit loop always works on larger - smaller.
            eff_sub   = op_q ^ sa_q;
            swap      = (a_q < b_q);
            eff_sub_d = eff_sub;
            rsign_d   = eff_sub ? (sa_q ^ swap) : sa_q;
            if (eff_sub && swap) begin
              a_d = b_q;
              b_d = a_q;
            end
            carry_d = 1'b0;
            res_d   = '0;
            cyc_d   = cyc_q + 1'b1;
          end else begin
            step    = bcd_step(a_q[3:0], b_q[3:0], carry_q, eff_sub_q);
            res_nxt = {step[3:0], res_q[W-1:4]};
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            carry_d = step[4];
            res_d   = res_nxt;
            cyc_d   = cyc_q + 1'b1;
            if (cyc_q == CW'(DIGITS)) begin
              cyc_d = '0;
              if (step[4] && !eff_sub_q) begin
                state_d = ERROR;
              end else begin
                a_d     = res_nxt;
                cnt_a_d = sig_count(res_nxt);
                sa_d    = (res_nxt != '0) & rsign_q;
                if (chain_q) begin
                  op_d    = next_op_q;
                  state_d = OP_WAIT;
                end else begin
                  state_d = SHOW;
                end
              end
            end
          end
        end
        SHOW: begin
          if (is_dig) begin
            enter_digit('0, '0, num, a_d, cnt_a_d);
            sa_d    = 1'b0;
            state_d = ENTER_A;
          end else if (is_op) begin
            op_d    = (num == KEY_SUB);
            state_d = OP_WAIT;
          end
        end
        default: ;
      endcase
    end

    // Display follows the next state so it updates on the same edge as the FSM.
    case (state_d)
      ERROR: begin
        disp_bcd_d = '0;  disp_blank_d = '1;  neg_d = 1'b0;
      end
      COMPUTE: ;
      ENTER_B: begin
        disp_bcd_d = b_d;  disp_blank_d = blank_mask(b_d);  neg_d = 1'b0;
      end
      default: begin
        disp_bcd_d = a_d;  disp_blank_d = blank_mask(a_d);  neg_d = sa_d;
      end
    endcase
    err_d  = (state_d == ERROR);
    busy_d = (state_d == COMPUTE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ENTER_A;  a_q <= '0;  b_q <= '0;  res_q <= '0;
      cnt_a_q <= '0;  cnt_b_q <= '0;  cyc_q <= '0;
      sa_q <= 1'b0;  op_q <= 1'b0;  next_op_q <= 1'b0;  chain_q <= 1'b0;
      eff_sub_q <= 1'b0;  rsign_q <= 1'b0;  carry_q <= 1'b0;  kp_prev_q <= 1'b0;
      disp_bcd_q <= '0;  disp_blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
      neg_q <= 1'b0;  err_q <= 1'b0;  busy_q <= 1'b0;
    end else begin
      state_q <= state_d;  a_q <= a_d;  b_q <= b_d;  res_q <= res_d;
      cnt_a_q <= cnt_a_d;  cnt_b_q <= cnt_b_d;  cyc_q <= cyc_d;
      sa_q <= sa_d;  op_q <= op_d;  next_op_q <= next_op_d;  chain_q <= chain_d;
      eff_sub_q <= eff_sub_d;  rsign_q <= rsign_d;  carry_q <= carry_d;  kp_prev_q <= kp_prev_d;
      disp_bcd_q <= disp_bcd_d;  disp_blank_q <= disp_blank_d;
      neg_q <= neg_d;  err_q <= err_d;  busy_q <= busy_d;
    end
  end

  assign disp_bcd   = disp_bcd_q;
  assign disp_blank = disp_blank_q;
  assign neg        = neg_q;
  assign err        = err_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_bcd_calc_core.sv
// Bench for bcd_calc_core: key-sequence table with a queue of expected displays,
// plus hand-timed sequences for reset, busy length and CLR abort.
module tb_bcd_calc_core;
  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  num;
  logic        keyPressed;
  logic [15:0] disp_bcd;
  logic [3:0]  disp_blank;
  logic        neg, err, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [31:0] keys;   // first key in the top nibble
    int          n;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        neg;
    logic        err;
    logic        chk_bcd;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  bcd_calc_core #(.DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .num(num), .keyPressed(keyPressed),
    .disp_bcd(disp_bcd), .disp_blank(disp_blank), .neg(neg), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, expv);
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy === 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: busy still %b after %0d cycles, want 0", name, busy, t);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    num        = k;
    keyPressed = 1'b1;
    repeat (2) @(negedge clk);
    keyPressed = 1'b0;
    @(negedge clk);
    wait_idle("press idle");
  endtask

  task automatic add_vec(input string nm, input logic [31:0] k, input int n,
                         input logic [15:0] b, input logic [3:0] bl,
                         input logic ng, input logic er, input logic cb);
    vec_t v;
    v.name = nm;  v.keys = k;  v.n = n;  v.bcd = b;  v.blank = bl;
    v.neg = ng;   v.err = er;  v.chk_bcd = cb;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t v, e;
    logic [3:0] key;
    int hi;

    reset = 1'b0;  num = 4'd0;  keyPressed = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset mid-stream with a key held.
    press(4'd7);
    press(4'd8);
    @(negedge clk);
    num = 4'd9;  keyPressed = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst bcd",   32'(disp_bcd),   32'h0000);
    check("rst blank", 32'(disp_blank), 32'b1110);
    check("rst neg",   32'(neg),  0);
    check("rst err",   32'(err),  0);
    check("rst busy",  32'(busy), 0);
    keyPressed = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // A key held for 20 cycles is a single entry.
    @(negedge clk);
    num = 4'd5;  keyPressed = 1'b1;
    repeat (20) @(negedge clk);
    keyPressed = 1'b0;
    repeat (2) @(negedge clk);
    check("hold bcd",   32'(disp_bcd),   32'h0005);
    check("hold blank", 32'(disp_blank), 32'b1110);
    press(4'hC);

    // Busy length after '='.
    press(4'd1); press(4'd2); press(4'd3); press(4'hA); press(4'd4); press(4'd5);
    check("entry B shown", 32'(disp_bcd), 32'h0045);
    @(negedge clk);
    num = 4'hE;  keyPressed = 1'b1;
    @(negedge clk);
    check("busy starts", 32'(busy), 1);
    keyPressed = 1'b0;
    hi = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy) hi++;
    end
    check("busy cycles", 32'(hi), 32'd5);
    check("sum bcd",   32'(disp_bcd),   32'h0168);
    check("sum blank", 32'(disp_blank), 32'b1000);
    check("sum neg",   32'(neg), 0);

    add_vec("add123_45",   32'hC123A45E, 8, 16'h0168, 4'b1000, 0, 0, 1);
    add_vec("sub10_25",    32'hC10B25E0, 7, 16'h0015, 4'b1100, 1, 0, 1);
    add_vec("chain_p5",    32'hA5E00000, 3, 16'h0010, 4'b1100, 1, 0, 1);
    add_vec("chain_p20",   32'hA20E0000, 4, 16'h0010, 4'b1100, 0, 0, 1);
    add_vec("overflow",    32'hC9999A1E, 8, 16'h0000, 4'b1111, 0, 1, 0);
    add_vec("err_ignores", 32'h3AE00000, 3, 16'h0000, 4'b1111, 0, 1, 0);
    add_vec("err_clr",     32'hC0000000, 1, 16'h0000, 4'b1110, 0, 0, 1);
    add_vec("entry_limit", 32'h12345000, 5, 16'h1234, 4'b0000, 0, 0, 1);
    add_vec("backspace",   32'hF0000000, 1, 16'h0123, 4'b1000, 0, 0, 1);
    add_vec("lead_zeros",  32'hC0000000, 3, 16'h0000, 4'b1110, 0, 0, 1);
    add_vec("bs_at_zero",  32'hF0000000, 1, 16'h0000, 4'b1110, 0, 0, 1);
    add_vec("key_d_ign",   32'hD7000000, 2, 16'h0007, 4'b1110, 0, 0, 1);
    add_vec("chain_2p3",   32'hC2A3A000, 5, 16'h0005, 4'b1110, 0, 0, 1);
    add_vec("chain_4eq",   32'h4E000000, 2, 16'h0009, 4'b1110, 0, 0, 1);
    add_vec("opwait_eq",   32'hAE000000, 2, 16'h0009, 4'b1110, 0, 0, 1);
    add_vec("op_replace",  32'hBA7E0000, 4, 16'h0016, 4'b1100, 0, 0, 1);
    add_vec("show_digit",  32'h80000000, 1, 16'h0008, 4'b1110, 0, 0, 1);
    add_vec("entera_eq",   32'hE0000000, 1, 16'h0008, 4'b1110, 0, 0, 1);
    add_vec("sub_zero",    32'hC5B5E000, 5, 16'h0000, 4'b1110, 0, 0, 1);
    add_vec("neg5",        32'hC3B8E000, 5, 16'h0005, 4'b1110, 1, 0, 1);
    add_vec("neg_to_zero", 32'hA5E00000, 3, 16'h0000, 4'b1110, 0, 0, 1);
    add_vec("carry_chain", 32'hC999A1E0, 7, 16'h1000, 4'b0000, 0, 0, 1);
    add_vec("neg1",        32'hC1B2E000, 5, 16'h0001, 4'b1110, 1, 0, 1);
    add_vec("neg_add",     32'hB99E0000, 4, 16'h0100, 4'b1000, 1, 0, 1);
    add_vec("show_bs",     32'hF0000000, 1, 16'h0100, 4'b1000, 1, 0, 1);
    add_vec("neg4",        32'hC1B5E000, 5, 16'h0004, 4'b1110, 1, 0, 1);
    add_vec("b_display",   32'hA7000000, 2, 16'h0007, 4'b1110, 0, 0, 1);
    add_vec("neg4_p7",     32'hE0000000, 1, 16'h0003, 4'b1110, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      exp_q.push_back(v);
      for (int k = 0; k < v.n; k++) begin
        key = v.keys[31-4*k -: 4];
        press(key);
      end
      wait_idle("vec idle");
      e = exp_q.pop_front();
      if (e.chk_bcd) check({e.name, " bcd"}, 32'(disp_bcd), 32'(e.bcd));
      check({e.name, " blank"}, 32'(disp_blank), 32'(e.blank));
      check({e.name, " neg"},   32'(neg), 32'(e.neg));
      check({e.name, " err"},   32'(err), 32'(e.err));
    end

    // CLR while busy aborts the computation and clears everything.
    press(4'hC); press(4'd1); press(4'hA); press(4'd1);
    @(negedge clk);
    num = 4'hE;  keyPressed = 1'b1;
    @(negedge clk);
    check("abort busy before", 32'(busy), 1);
    keyPressed = 1'b0;
    @(negedge clk);
    num = 4'hC;  keyPressed = 1'b1;
    @(negedge clk);
    keyPressed = 1'b0;
    check("abort busy",  32'(busy), 0);
    check("abort bcd",   32'(disp_bcd), 32'h0000);
    check("abort blank", 32'(disp_blank), 32'b1110);
    repeat (8) @(negedge clk);
    check("abort stays clear", 32'(disp_bcd), 32'h0000);
    check("abort busy later",  32'(busy), 0);
    press(4'd3);
    check("after abort entry", 32'(disp_bcd), 32'h0003);
    check("after abort neg",   32'(neg), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
